// File: rtl/demo_stage_pkg.sv
// ---------------------------------------------------------------------------
// demo_stage_pkg
// Shared definitions for the demo_stage_xfer datapath stage.
//   RES_*     : bit positions inside the 4-bit status code (result_t)
//   STATS_W   : width of the optional beat statistics counters
//   max_int   : elaboration-time helper for sizing intermediate vectors
// ---------------------------------------------------------------------------
package demo_stage_pkg;

   localparam int RES_WRAP  = 0;
   localparam int RES_TRUNC = 1;
   localparam int RES_PAR   = 2;
   localparam int RES_DROP  = 3;

   localparam int STATS_W = 16;

   typedef logic [3:0] result_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/demo_stage_fifo.sv
// ---------------------------------------------------------------------------
// demo_stage_fifo
// Synchronous FIFO, DEPTH entries (power of 2, >= 2), WIDTH bits per entry.
// A push is accepted when not full, or when full and a pop happens in the
// same cycle (the freed slot is reused, count unchanged). A pop on empty is
// ignored. rd_data always shows the head entry (valid when !empty).
// Ports:
//   clk, rst_n         clock, synchronous active-low reset (pointers/count)
//   push, wr_data      write request and data
//   pop                read request (advances head)
//   rd_data            head entry
//   full, empty, count occupancy status
// ---------------------------------------------------------------------------
module demo_stage_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // DEPTH is a power of 2, so the pointers wrap by plain overflow.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: entries are only read after being written.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = mem[rd_ptr];
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);

endmodule

// File: rtl/demo_stage_xfer.sv
// ---------------------------------------------------------------------------
// demo_stage_xfer
// Datapath stage on the demo bus: remaps the address (zero-extend + offset),
// resizes the data, builds a 4-bit status code, and buffers beats in a FIFO
// so a throttled output (at least OUT_GAP idle cycles between vld_o pulses)
// can absorb input bursts. Beats arriving to a full FIFO are dropped and a
// sticky drop flag is reported on the next emitted beat.
//
// Handshake: vld_i qualifies addr_i/data_i for one cycle, with no
// backpressure -- a beat is either accepted or dropped. vld_o is a
// single-cycle pulse per emitted beat; addr_o/data_o/result hold their last
// values while vld_o is low.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   vld_i, addr_i, data_i    input beat
//   vld_o, addr_o, data_o    output beat (registered)
//   result                   status: [0] wrap [1] trunc [2] parity [3] drop
// Optional (macro DEMO_STAGE_XFER_STATS_EN):
//   acc_cnt, drop_cnt        saturating counts of emitted / dropped beats
// ---------------------------------------------------------------------------
module demo_stage_xfer
   import demo_stage_pkg::*;
#(
   parameter int                    ADDR_I_WIDTH = 8,
   parameter int                    DATA_I_WIDTH = 16,
   parameter int                    ADDR_O_WIDTH = 8,
   parameter int                    DATA_O_WIDTH = 16,
   parameter logic [ADDR_O_WIDTH-1:0] ADDR_OFFSET = '0,
   parameter int                    FIFO_DEPTH   = 4,
   parameter int                    OUT_GAP      = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     vld_i,
   input  logic [ADDR_I_WIDTH-1:0]  addr_i,
   input  logic [DATA_I_WIDTH-1:0]  data_i,
   output logic                     vld_o,
   output logic [ADDR_O_WIDTH-1:0]  addr_o,
   output logic [DATA_O_WIDTH-1:0]  data_o,
   output result_t                  result
`ifdef DEMO_STAGE_XFER_STATS_EN
   ,
   output logic [STATS_W-1:0]       acc_cnt,
   output logic [STATS_W-1:0]       drop_cnt
`endif
);

   localparam int AW       = max_int(ADDR_I_WIDTH, ADDR_O_WIDTH) + 1;
   localparam int DW       = max_int(DATA_I_WIDTH, DATA_O_WIDTH);
   // Beat layout: {par, trunc, wrap, data, addr}; flag bits line up with RES_*.
   localparam int FLAG_LSB = ADDR_O_WIDTH + DATA_O_WIDTH;
   localparam int BEAT_W   = FLAG_LSB + 3;
   localparam int GAP_W    = (OUT_GAP > 0) ? $clog2(OUT_GAP + 1) : 1;

   // ---------------- stage 1: transform and register ----------------
   logic [AW-1:0]     a_sum;
   logic [DW-1:0]     d_ext;
   logic [BEAT_W-1:0] beat_in;
   logic              s1_vld;
   logic [BEAT_W-1:0] s1_beat;

   assign a_sum = AW'(addr_i) + AW'(ADDR_OFFSET);
   assign d_ext = DW'(data_i);

   always_comb begin
      beat_in = '0;
      beat_in[ADDR_O_WIDTH-1:0]            = a_sum[ADDR_O_WIDTH-1:0];
      beat_in[ADDR_O_WIDTH +: DATA_O_WIDTH] = DATA_O_WIDTH'(data_i);
      // Anything left after shifting out the kept bits was lost.
      beat_in[FLAG_LSB + RES_WRAP]          = |(a_sum >> ADDR_O_WIDTH);
      beat_in[FLAG_LSB + RES_TRUNC]         = |(d_ext >> DATA_O_WIDTH);
      beat_in[FLAG_LSB + RES_PAR]           = ^data_i;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_vld  <= 1'b0;
         s1_beat <= '0;
      end else begin
         s1_vld  <= vld_i;
         s1_beat <= beat_in;
      end
   end

   // ---------------- stage 2: buffer, throttle, emit ----------------
   logic [GAP_W-1:0]          gap_cnt;
   logic                      drop_flag;
   logic                      permit;
   logic                      pop;
   logic                      bypass;
   logic                      push;
   logic                      drop;
   logic                      emit;
   logic [BEAT_W-1:0]         emit_beat;
   result_t                   emit_res;
   logic [BEAT_W-1:0]         fifo_rd_data;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic                      unused_fifo_count;

   // Occupancy is not needed here; full/empty cover every decision.
   assign unused_fifo_count = ^fifo_count;

   // Buffered beats go first so arrival order is preserved; a new beat
   // bypasses the FIFO only when nothing older is waiting.
   assign permit    = (gap_cnt == '0);
   assign pop       = permit && !fifo_empty;
   assign bypass    = permit && fifo_empty && s1_vld;
   assign push      = s1_vld && !bypass;
   assign drop      = push && fifo_full && !pop;
   assign emit      = pop || bypass;
   assign emit_beat = pop ? fifo_rd_data : s1_beat;

   always_comb begin
      emit_res            = '0;
      emit_res[RES_WRAP]  = emit_beat[FLAG_LSB + RES_WRAP];
      emit_res[RES_TRUNC] = emit_beat[FLAG_LSB + RES_TRUNC];
      emit_res[RES_PAR]   = emit_beat[FLAG_LSB + RES_PAR];
      emit_res[RES_DROP]  = drop_flag;   // value before this cycle's update
   end

   demo_stage_fifo #(
      .WIDTH (BEAT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .wr_data (s1_beat),
      .pop     (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_o     <= 1'b0;
         addr_o    <= '0;
         data_o    <= '0;
         result    <= '0;
         gap_cnt   <= '0;
         drop_flag <= 1'b0;
      end else begin
         vld_o <= emit;
         if (emit) begin
            addr_o <= emit_beat[ADDR_O_WIDTH-1:0];
            data_o <= emit_beat[ADDR_O_WIDTH +: DATA_O_WIDTH];
            result <= emit_res;
         end
         // Loaded together with vld_o, so the pulse cycle counts as busy and
         // OUT_GAP idle cycles follow before the next permit.
         if (emit)
            gap_cnt <= GAP_W'(OUT_GAP);
         else if (gap_cnt != '0)
            gap_cnt <= gap_cnt - GAP_W'(1);
         // A drop wins over the clear so a coinciding drop is not lost.
         if (drop)
            drop_flag <= 1'b1;
         else if (emit)
            drop_flag <= 1'b0;
      end
   end

`ifdef DEMO_STAGE_XFER_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_cnt  <= '0;
         drop_cnt <= '0;
      end else begin
         if (emit && (acc_cnt != '1))  acc_cnt  <= acc_cnt + STATS_W'(1);
         if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + STATS_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_demo_stage_xfer.sv
// ---------------------------------------------------------------------------
// tb_demo_stage_xfer
// Two instances share one input stream:
//   dut_a : ADDR_OFFSET=8'h20, OUT_GAP=2, FIFO_DEPTH=4, 16-bit data out
//   dut_b : ADDR_OFFSET=0, OUT_GAP=0, 8-bit data out (truncating)
// A transaction-level model (pending-beat queue, cooldown, sticky flag) runs
// beside them; a compare process checks every output each cycle, and
// directed sections pin hand-computed values.
// ---------------------------------------------------------------------------
module tb_demo_stage_xfer;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        vld_i;
   logic [7:0]  addr_i;
   logic [15:0] data_i;

   logic        a_vld;
   logic [7:0]  a_addr;
   logic [15:0] a_data;
   logic [3:0]  a_res;
   logic        b_vld;
   logic [7:0]  b_addr;
   logic [7:0]  b_data;
   logic [3:0]  b_res;
`ifdef DEMO_STAGE_XFER_STATS_EN
   logic [15:0] a_acc, a_drop, b_acc, b_drop;
`endif

   demo_stage_xfer #(
      .ADDR_OFFSET (8'h20),
      .FIFO_DEPTH  (4),
      .OUT_GAP     (2)
   ) dut_a (
      .clk    (clk),
      .rst_n  (rst_n),
      .vld_i  (vld_i),
      .addr_i (addr_i),
      .data_i (data_i),
      .vld_o  (a_vld),
      .addr_o (a_addr),
      .data_o (a_data),
      .result (a_res)
`ifdef DEMO_STAGE_XFER_STATS_EN
      ,
      .acc_cnt  (a_acc),
      .drop_cnt (a_drop)
`endif
   );

   demo_stage_xfer #(
      .DATA_O_WIDTH (8),
      .ADDR_OFFSET  (8'h00),
      .OUT_GAP      (0)
   ) dut_b (
      .clk    (clk),
      .rst_n  (rst_n),
      .vld_i  (vld_i),
      .addr_i (addr_i),
      .data_i (data_i),
      .vld_o  (b_vld),
      .addr_o (b_addr),
      .data_o (b_data),
      .result (b_res)
`ifdef DEMO_STAGE_XFER_STATS_EN
      ,
      .acc_cnt  (b_acc),
      .drop_cnt (b_drop)
`endif
   );

   // ---------------- scoreboard counters ----------------
   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   logic chk_en    = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc++;

   // ---------------- reference model ----------------
   // Beats as {par, trunc, wrap, data, addr}, derived with plain arithmetic.
   function automatic logic [26:0] beat_a(input logic [7:0] a, input logic [15:0] d);
      int s;
      logic w, p;
      logic [7:0] lo;
      s  = int'(a) + 32'h20;
      w  = (s > 255);
      lo = 8'(s % 256);
      p  = (($countones(d) % 2) == 1);
      return {p, 1'b0, w, d, lo};
   endfunction

   function automatic logic [18:0] beat_b(input logic [7:0] a, input logic [15:0] d);
      logic t, p;
      t = (d > 16'd255);
      p = (($countones(d) % 2) == 1);
      return {p, t, 1'b0, d[7:0], a};
   endfunction

   localparam int A_GAP   = 2;
   localparam int A_DEPTH = 4;

   logic [26:0] exp_q[$];        // beats waiting in dut_a
   logic        a_cand_vld;
   logic [26:0] a_cand;
   int          a_cool;
   logic        a_flag;
   logic        ea_vld;
   logic [7:0]  ea_addr;
   logic [15:0] ea_data;
   logic [3:0]  ea_res;
   int          ea_acc, ea_drop;

   logic        b_cand_vld;
   logic [18:0] b_cand;
   logic        eb_vld;
   logic [7:0]  eb_addr;
   logic [7:0]  eb_data;
   logic [3:0]  eb_res;
   int          eb_acc;

   always @(posedge clk) begin
      logic        emitted;
      logic        dropped;
      logic [26:0] hb;
      if (!rst_n) begin
         exp_q.delete();
         a_cand_vld = 1'b0; a_cand = '0; a_cool = 0; a_flag = 1'b0;
         ea_vld = 1'b0; ea_addr = '0; ea_data = '0; ea_res = '0;
         ea_acc = 0; ea_drop = 0;
         b_cand_vld = 1'b0; b_cand = '0;
         eb_vld = 1'b0; eb_addr = '0; eb_data = '0; eb_res = '0; eb_acc = 0;
      end else begin
         emitted = 1'b0;
         dropped = 1'b0;
         ea_vld  = 1'b0;
         if (a_cool == 0 && (exp_q.size() > 0 || a_cand_vld)) begin
            if (exp_q.size() > 0) hb = exp_q.pop_front();
            else begin
               hb = a_cand;
               a_cand_vld = 1'b0;
            end
            emitted = 1'b1;
            ea_vld  = 1'b1;
            ea_addr = hb[7:0];
            ea_data = hb[23:8];
            ea_res  = {a_flag, hb[26:24]};
            a_cool  = A_GAP;
            if (ea_acc < 65535) ea_acc++;
         end else if (a_cool > 0) begin
            a_cool--;
         end
         if (a_cand_vld) begin
            if (exp_q.size() < A_DEPTH) exp_q.push_back(a_cand);
            else begin
               dropped = 1'b1;
               if (ea_drop < 65535) ea_drop++;
            end
         end
         if (dropped) a_flag = 1'b1;
         else if (emitted) a_flag = 1'b0;
         a_cand_vld = vld_i;
         a_cand     = beat_a(addr_i, data_i);

         // dut_b is never throttled: every beat appears two cycles later.
         eb_vld = b_cand_vld;
         if (b_cand_vld) begin
            eb_addr = b_cand[7:0];
            eb_data = b_cand[15:8];
            eb_res  = {1'b0, b_cand[18:16]};
            eb_acc++;
         end
         b_cand_vld = vld_i;
         b_cand     = beat_b(addr_i, data_i);
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         chk("a_vld",  32'(a_vld),  32'(ea_vld));
         chk("a_addr", 32'(a_addr), 32'(ea_addr));
         chk("a_data", 32'(a_data), 32'(ea_data));
         chk("a_res",  32'(a_res),  32'(ea_res));
         chk("b_vld",  32'(b_vld),  32'(eb_vld));
         chk("b_addr", 32'(b_addr), 32'(eb_addr));
         chk("b_data", 32'(b_data), 32'(eb_data));
         chk("b_res",  32'(b_res),  32'(eb_res));
`ifdef DEMO_STAGE_XFER_STATS_EN
         chk("a_acc",  32'(a_acc),  32'(ea_acc));
         chk("a_drop", 32'(a_drop), 32'(ea_drop));
         chk("b_acc",  32'(b_acc),  32'(eb_acc));
         chk("b_drop", 32'(b_drop), 32'd0);
`endif
      end
   end

   // ---------------- capture of dut_a emissions ----------------
   logic cap_en = 1'b0;
   int   cap_id[$];
   logic cap_flag[$];
   int   cap_cyc[$];

   always @(negedge clk) begin
      if (cap_en && a_vld === 1'b1) begin
         cap_id.push_back(int'(a_data));
         cap_flag.push_back(a_res[3]);
         cap_cyc.push_back(cyc);
      end
   end

   // ---------------- driver ----------------
   // Called at a negedge: applies inputs, returns at the next negedge.
   task automatic step(input logic v, input logic [7:0] a, input logic [15:0] d);
      vld_i  = v;
      addr_i = a;
      data_i = d;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 16'h0000);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      step(1'b0, 8'h00, 16'h0000);
      rst_n = 1'b1;
   endtask

   int exp_ids[8]   = '{0, 1, 2, 3, 4, 5, 6, 9};
   logic exp_flg[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

   initial begin
      rst_n  = 1'b0;
      vld_i  = 1'b0;
      addr_i = '0;
      data_i = '0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;

      // reset state
      chk("rst_a_vld",  32'(a_vld),  32'd0);
      chk("rst_a_addr", 32'(a_addr), 32'd0);
      chk("rst_a_data", 32'(a_data), 32'd0);
      chk("rst_a_res",  32'(a_res),  32'd0);
      rst_n = 1'b1;
      idle(2);

      // basic remap: latency t+2, not t+1
      step(1'b1, 8'h10, 16'h1234);
      chk("lat_not_t1", 32'(a_vld), 32'd0);
      step(1'b0, 8'h00, 16'h0000);
      chk("t1_vld",  32'(a_vld),  32'd1);
      chk("t1_addr", 32'(a_addr), 32'h30);
      chk("t1_data", 32'(a_data), 32'h1234);
      chk("t1_res",  32'(a_res),  32'b0100);
      chk("t1_b_data", 32'(b_data), 32'h34);
      chk("t1_b_res",  32'(b_res),  32'b0110);
      idle(4);

      // address wrap
      step(1'b1, 8'hF0, 16'h0000);
      step(1'b0, 8'h00, 16'h0000);
      chk("wrap_addr", 32'(a_addr), 32'h10);
      chk("wrap_res",  32'(a_res),  32'b0001);
      idle(4);

      // data truncation on dut_b
      step(1'b1, 8'h00, 16'h0155);
      step(1'b0, 8'h00, 16'h0000);
      chk("trunc_vld",  32'(b_vld),  32'd1);
      chk("trunc_data", 32'(b_data), 32'h55);
      chk("trunc_res",  32'(b_res),  32'b0110);
      idle(4);

      // 12-beat burst into the throttled instance
      pulse_reset();
      cap_en = 1'b1;
      for (int k = 0; k < 12; k++) step(1'b1, 8'h00, 16'(k));
      idle(30);
      cap_en = 1'b0;
      chk("burst_count", 32'(cap_id.size()), 32'd8);
      for (int i = 0; i < cap_id.size() && i < 8; i++) begin
         chk("burst_order", 32'(cap_id[i]), 32'(exp_ids[i]));
         chk("burst_flag",  32'(cap_flag[i]), 32'(exp_flg[i]));
         if (i > 0) chk("burst_gap", 32'(cap_cyc[i] - cap_cyc[i-1]), 32'd3);
      end
`ifdef DEMO_STAGE_XFER_STATS_EN
      chk("burst_acc",  32'(a_acc),  32'd8);
      chk("burst_drop", 32'(a_drop), 32'd4);
`endif

      // reset with beats buffered and one in flight
      for (int k = 0; k < 6; k++) step(1'b1, 8'(k), 16'(16'hA000 + k));
      pulse_reset();
      for (int i = 0; i < 6; i++) begin
         chk("post_rst_vld",  32'(a_vld),  32'd0);
         chk("post_rst_addr", 32'(a_addr), 32'd0);
         chk("post_rst_data", 32'(a_data), 32'd0);
         chk("post_rst_res",  32'(a_res),  32'd0);
         step(1'b0, 8'h00, 16'h0000);
      end
      step(1'b1, 8'h05, 16'h00FF);
      chk("after_rst_t1", 32'(a_vld), 32'd0);
      step(1'b0, 8'h00, 16'h0000);
      chk("after_rst_vld",  32'(a_vld),  32'd1);
      chk("after_rst_addr", 32'(a_addr), 32'h25);
      chk("after_rst_data", 32'(a_data), 32'h00FF);
      chk("after_rst_res",  32'(a_res),  32'd0);
      idle(4);

      // randomized traffic: dense, then sparse, with one reset in between
      for (int i = 0; i < 500; i++) begin
         int dens;
         dens = (i < 250) ? 75 : 30;
         if (i == 320) pulse_reset();
         step(($urandom_range(99) < dens), 8'($urandom_range(255)), 16'($urandom_range(65535)));
      end
      idle(30);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
